// File: rtl/framebuffer_dma_pkg.sv
// Shared state type and panel geometry for the framebuffer-to-LED-panel copy engine.
package framebuffer_dma_pkg;

    localparam int PANEL_W = 32;
    localparam int PANEL_H = 32;
    localparam int X_W     = $clog2(PANEL_W);
    localparam int Y_W     = $clog2(PANEL_H);
    localparam int IDX_W   = X_W + Y_W;
    localparam int RGB_W   = 24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WR,
        ST_DONE
    } state_t;

endpackage

// File: rtl/framebuffer_dma.sv
// Read-only bus initiator that copies a framebuffer from RAM to the LED panel write port.
// Define FRAMEBUFFER_DMA_CONTINUOUS_EN to refresh frames back to back after a single start.
module framebuffer_dma
    import framebuffer_dma_pkg::*;
#(
    parameter logic [31:0] FB_BASE = 32'h0000_1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             mem_valid,
    output logic [31:0]      mem_addr,
    output logic [3:0]       mem_wstrb,
    input  logic             mem_ready,
    input  logic [31:0]      mem_rdata,
    output logic             led_wr_enable,
    output logic [X_W-1:0]   led_wr_addr_x,
    output logic [Y_W-1:0]   led_wr_addr_y,
    output logic [RGB_W-1:0] led_wr_rgb_data
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [RGB_W-1:0]   rgb_q, rgb_d;
    logic               last_pix;
    logic               unused_rdata;

    // Upper byte of each pixel word carries no colour information.
    assign unused_rdata = ^mem_rdata[31:RGB_W];
    assign last_pix     = &idx_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rgb_d   = rgb_q;
        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                if (start) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_ready) begin
                    rgb_d   = mem_rdata[RGB_W-1:0];
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = last_pix ? ST_DONE : ST_REQ;
            end
            ST_DONE: begin
`ifdef FRAMEBUFFER_DMA_CONTINUOUS_EN
                state_d = ST_REQ;
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            rgb_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rgb_q   <= rgb_d;
        end
    end

    // Outputs decode straight from the flops so a reset clears them without waiting for a clock.
    assign busy            = (state_q != ST_IDLE);
    assign done            = (state_q == ST_DONE);
    assign mem_valid       = (state_q == ST_REQ);
    assign mem_addr        = mem_valid ? (FB_BASE + 32'({idx_q, 2'b00})) : 32'h0;
    assign mem_wstrb       = 4'b0000;
    assign led_wr_enable   = (state_q == ST_WR);
    assign led_wr_addr_x   = idx_q[X_W-1:0];
    assign led_wr_addr_y   = idx_q[IDX_W-1:X_W];
    assign led_wr_rgb_data = rgb_q;

endmodule

// File: tb/tb_framebuffer_dma.sv
// Directed/randomized bench for framebuffer_dma: RAM responder plus a per-pixel reference model.
module tb_framebuffer_dma;

    logic        clk;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        led_wr_enable;
    logic [4:0]  led_wr_addr_x;
    logic [4:0]  led_wr_addr_y;
    logic [23:0] led_wr_rgb_data;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] fb_mem [1024];

    // Reference-model / responder state, all owned by the single stimulus process.
    int          wr_cnt, rd_cnt, done_cnt;
    int          stall_limit, min_wait, max_wait;
    bit          inject;
    int          wait_left;
    bit          ack_pending, prev_pend, prev_wr;
    logic [31:0] prev_addr;

    framebuffer_dma dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .mem_valid       (mem_valid),
        .mem_addr        (mem_addr),
        .mem_wstrb       (mem_wstrb),
        .mem_ready       (mem_ready),
        .mem_rdata       (mem_rdata),
        .led_wr_enable   (led_wr_enable),
        .led_wr_addr_x   (led_wr_addr_x),
        .led_wr_addr_y   (led_wr_addr_y),
        .led_wr_rgb_data (led_wr_rgb_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe/respond on the falling edge, return 2 time units after the next rising edge.
    task automatic tick();
        int          n;
        logic [31:0] w;
        logic [31:0] off;
        @(negedge clk);
        if (reset) begin
            mem_ready   = 1'b0;
            ack_pending = 1'b0;
            prev_pend   = 1'b0;
            prev_wr     = 1'b0;
            wait_left   = -1;
        end else begin
            if (mem_ready) begin
                if (ack_pending) begin
                    check("rd_addr", prev_addr, 32'h1000 + 32'(4 * (rd_cnt % 1024)));
                    check("valid_drop", 32'(mem_valid), 32'd0);
                    rd_cnt++;
                end
                mem_ready   = 1'b0;
                ack_pending = 1'b0;
                wait_left   = -1;
            end else if (prev_pend) begin
                check("valid_held", 32'(mem_valid), 32'd1);
                check("addr_held", mem_addr, prev_addr);
            end
            if (led_wr_enable) begin
                n = wr_cnt % 1024;
                w = fb_mem[n];
                check("pix_x", 32'(led_wr_addr_x), 32'(n % 32));
                check("pix_y", 32'(led_wr_addr_y), 32'(n / 32));
                check("pix_rgb", 32'(led_wr_rgb_data), {8'h00, w[23:0]});
                wr_cnt++;
            end
            if (done) begin
                check("done_pos", 32'({prev_wr, (wr_cnt > 0) && (wr_cnt % 1024 == 0)}), 32'd3);
                done_cnt++;
            end
            prev_wr = led_wr_enable;
            if (inject) begin
                mem_ready   = 1'b1;
                mem_rdata   = $urandom;
                ack_pending = 1'b0;
                inject      = 1'b0;
            end else if (mem_valid && rd_cnt < stall_limit) begin
                if (wait_left < 0) wait_left = $urandom_range(max_wait, min_wait);
                if (wait_left == 0) begin
                    check("wstrb", 32'(mem_wstrb), 32'd0);
                    off         = (mem_addr - 32'h1000) >> 2;
                    mem_rdata   = fb_mem[off[9:0]];
                    mem_ready   = 1'b1;
                    ack_pending = 1'b1;
                end else begin
                    wait_left--;
                end
            end else if (!mem_valid) begin
                wait_left = -1;
            end
            prev_pend = mem_valid && !mem_ready;
            prev_addr = mem_addr;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic clear_model();
        wr_cnt   = 0;
        rd_cnt   = 0;
        done_cnt = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_dones(input int target, input int budget);
        int c = 0;
        while (done_cnt < target && c < budget) begin
            tick();
            c++;
        end
        check("done_timeout", 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_valid"}, 32'(mem_valid), 32'd0);
        check({tag, "_addr"}, mem_addr, 32'd0);
        check({tag, "_wren"}, 32'(led_wr_enable), 32'd0);
    endtask

    initial begin
        int c;
        reset       = 1'b1;
        start       = 1'b0;
        mem_ready   = 1'b0;
        mem_rdata   = 32'h0;
        inject      = 1'b0;
        wait_left   = -1;
        ack_pending = 1'b0;
        prev_pend   = 1'b0;
        prev_wr     = 1'b0;
        prev_addr   = 32'h0;
        stall_limit = 32'h7fff_ffff;
        min_wait    = 1;
        max_wait    = 1;
        clear_model();
        for (int i = 0; i < 1024; i++) fb_mem[i] = 32'hFF00_0000 | 32'(i);

        tick();
        tick();
        check_idle_outputs("rst");
        check("rst_wstrb", 32'(mem_wstrb), 32'd0);
        check("rst_x", 32'(led_wr_addr_x), 32'd0);
        check("rst_rgb", 32'(led_wr_rgb_data), 32'd0);
        reset = 1'b0;
        tick();
        check("post_rst_busy", 32'(busy), 32'd0);

`ifndef FRAMEBUFFER_DMA_CONTINUOUS_EN
        // Pattern frame, one-wait responder.
        clear_model();
        pulse_start();
        check("t1_busy", 32'(busy), 32'd1);
        wait_dones(1, 12000);
        check("t1_busy_after", 32'(busy), 32'd0);
        check("t1_writes", 32'(wr_cnt), 32'd1024);
        check("t1_reads", 32'(rd_cnt), 32'd1024);
        check("t1_dones", 32'(done_cnt), 32'd1);

        // Random data, random 0..5 waits, start offered in the DONE cycle.
        for (int i = 0; i < 1024; i++) fb_mem[i] = $urandom;
        min_wait = 0;
        max_wait = 5;
        clear_model();
        pulse_start();
        c = 0;
        while (!done && c < 12000) begin
            tick();
            c++;
        end
        check("t2_done_seen", 32'(done), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t2_start_in_done", 32'(busy), 32'd0);
        tick();
        check("t2_still_idle", 32'(busy), 32'd0);
        check("t2_writes", 32'(wr_cnt), 32'd1024);
        check("t2_reads", 32'(rd_cnt), 32'd1024);
        check("t2_dones", 32'(done_cnt), 32'd1);

        // Start pulsed mid-frame is ignored.
        for (int i = 0; i < 1024; i++) fb_mem[i] = $urandom;
        clear_model();
        pulse_start();
        c = 0;
        while (wr_cnt < 100 && c < 2000) begin
            tick();
            c++;
        end
        pulse_start();
        wait_dones(1, 12000);
        tick();
        check("t3_writes", 32'(wr_cnt), 32'd1024);
        check("t3_dones", 32'(done_cnt), 32'd1);
        check("t3_busy", 32'(busy), 32'd0);

        // Reset while the 501st read is outstanding, then a stray ready, then a fresh frame.
        clear_model();
        stall_limit = 500;
        pulse_start();
        c = 0;
        while (!(rd_cnt == 500 && mem_valid) && c < 8000) begin
            tick();
            c++;
        end
        tick();
        tick();
        check("t4_stalled_valid", 32'(mem_valid), 32'd1);
        check("t4_stalled_addr", mem_addr, 32'h1000 + 32'(4 * 500));
        check("t4_writes_before", 32'(wr_cnt), 32'd500);
        reset = 1'b1;
        #1;
        check_idle_outputs("t4_async");
        tick();
        reset       = 1'b0;
        stall_limit = 32'h7fff_ffff;
        inject      = 1'b1;
        tick();
        tick();
        tick();
        check("t4_late_ready_busy", 32'(busy), 32'd0);
        check("t4_late_ready_wr", 32'(wr_cnt), 32'd500);
        check("t4_late_ready_rd", 32'(rd_cnt), 32'd500);
        clear_model();
        pulse_start();
        check("t4_restart_addr", mem_addr, 32'h0000_1000);
        wait_dones(1, 12000);
        check("t4_writes", 32'(wr_cnt), 32'd1024);
        check("t4_dones", 32'(done_cnt), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);
`else
        // Continuous refresh: two frames back to back from one start.
        for (int i = 0; i < 1024; i++) fb_mem[i] = $urandom;
        min_wait = 0;
        max_wait = 5;
        clear_model();
        pulse_start();
        wait_dones(2, 30000);
        check("t5_writes", 32'(wr_cnt), 32'd2048);
        check("t5_reads", 32'(rd_cnt), 32'd2048);
        check("t5_busy", 32'(busy), 32'd1);
        check("t5_rerequest", 32'(mem_valid), 32'd1);
        check("t5_rewrap_addr", mem_addr, 32'h0000_1000);
        reset = 1'b1;
        #1;
        check_idle_outputs("t5_stop");
        tick();
        reset = 1'b0;
        tick();
        check("t5_stays_idle", 32'(busy), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
